mul_iter_ctrl: RTL and testbench
================================

MUL_ITER_CTRL -- requirements
Module: mul_iter_ctrl

Interface
REQ-001 SHALL have parameter N, default 10, meaning operand width in bits; legal range N >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair x/y presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port x  input  N  multiplicand, unsigned.
REQ-007 SHALL have port y  input  N  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  z holds a finished product.
REQ-009 SHALL have port out_ready  input  1  consumer takes z.
REQ-010 SHALL have port z  output  2N  product x*y, registered.
REQ-011 SHALL have port busy  output  1  high while iterations are in progress.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; busy = 1 only in RUN; out_valid = 1 only in DONE.
REQ-014 SHALL accept on edge with in_valid & in_ready: latch x into multiplicand register, y into N-bit multiplier register, clear 2N-bit accumulator, clear iteration counter (width clog2(N+1)), go RUN.
REQ-015 SHALL perform exactly one partial-product row per RUN edge: if multiplier LSB = 1, upper N bits of accumulator += multiplicand as an (N+1)-bit sum; then {carry, accumulator} shifted right one bit; multiplier shifted right one bit; counter +1.
REQ-016 SHALL transition RUN -> DONE on the edge that completes iteration N, loading z with the full product; out_valid thus rises N cycles after the accept edge.
REQ-017 SHALL hold z and out_valid stable in DONE until out_valid & out_ready; on that edge go IDLE; out_valid falls and in_ready rises the following cycle.
REQ-018 SHALL NOT accept in the same cycle as the DONE handshake (in_ready = 0 in DONE); earliest next accept is one cycle after it; throughput is one product per N+2 cycles minimum.
REQ-019 SHALL ignore in_valid, x and y outside IDLE; operand changes after accept SHALL NOT affect the result.
REQ-020 SHALL ignore out_ready outside DONE.
REQ-021 SHALL keep z at its last product value in IDLE and RUN (z updates only on RUN -> DONE).
REQ-022 SHALL produce exact results for all operands, including x = 2^N-1, y = 2^N-1 (no truncation, carry into bit 2N-1 kept).

Reset
REQ-023 SHALL, on rst_n low, asynchronously force: state IDLE, in_ready 1, out_valid 0, busy 0, z 0, accumulator 0, multiplier 0, counter 0.
REQ-024 SHALL abort any operation in RUN or DONE on reset; no result from the aborted operation is ever presented.
REQ-025 SHALL resume normal acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro MUL_ITER_EARLY_EXIT_EN.
REQ-027 With MUL_ITER_EARLY_EXIT_EN defined: on a RUN edge where the updated multiplier register is zero, SHALL go DONE that edge with z = accumulator right-shifted by the remaining iteration count (N - counter); latency = max(1, msb_index(y)+1) cycles; y = 0 gives latency 1, z = 0.
REQ-028 Without MUL_ITER_EARLY_EXIT_EN: latency SHALL always be exactly N cycles; no shifter logic present.
REQ-029 z values SHALL be identical in both configurations for every operand pair.

Verification (N = 10)
REQ-030 x=1023, y=1023, out_ready=1 -> z=1046529 (0xFF801), out_valid exactly 10 cycles after accept, busy high those 10 cycles.
REQ-031 x=37, y=0 -> z=0; latency 10 without macro, 1 with MUL_ITER_EARLY_EXIT_EN.
REQ-032 x=100, y=5 with macro -> z=500, latency 3; without macro latency 10, same z.
REQ-033 x=12, y=13, out_ready low 5 cycles after out_valid -> z=156 stable, in_ready 0 throughout, second pair x=7, y=9 accepted only one cycle after the handshake -> z=63.
REQ-034 accept x=500, y=600, drive x/y to 0 and pulse in_valid during RUN -> z=300000, no extra accept.
REQ-035 assert rst_n low at RUN iteration 4 -> all outputs at reset values immediately; after release, x=3, y=4 -> z=12 with normal latency.

Source files
------------

// File: rtl/mul_iter_ctrl.sv
// -----------------------------------------------------------------------------
// mul_iter_ctrl
//
// Iterative unsigned shift-and-add multiplier with valid/ready handshakes on
// both sides. It computes one partial-product row per clock, so a product
// takes N cycles after the operands are accepted.
//
// Optional feature (compile-time macro):
//   MUL_ITER_EARLY_EXIT_EN - finish as soon as no multiplier bits remain.
//   The accumulator is then right-aligned with a shifter. The latency becomes
//   max(1, msb_index(y)+1) cycles. The product value is the same as in the
//   default build.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair x/y presented
//   in_ready   high only in IDLE; operands are accepted on in_valid & in_ready
//   x, y       N-bit unsigned multiplicand / multiplier
//   out_valid  high only in DONE; z holds a finished product
//   out_ready  consumer takes z; the handshake returns the block to IDLE
//   z          2N-bit registered product; it changes only on RUN -> DONE
//   busy       high only in RUN
// -----------------------------------------------------------------------------
module mul_iter_ctrl #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] z,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [N-1:0]     mcand_q,  mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2*N-1:0]   z_q,      z_d;

    // One row of the multiplication. The upper half of the accumulator gets
    // the multiplicand added as an (N+1)-bit sum, so the carry is kept. Then
    // {carry, accumulator} shifts right by one bit.
    logic [N:0]       row_sum;
    logic [2*N-1:0]   acc_step;
    logic [N-1:0]     mplier_step;
    logic [CW-1:0]    cnt_step;

    always_comb begin
        row_sum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, (mplier_q[0] ? mcand_q : {N{1'b0}})};
        acc_step    = {row_sum, acc_q[N-1:1]};
        mplier_step = mplier_q >> 1;
        cnt_step    = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        z_d      = z_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = x;
                    mplier_d = y;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_step;
`ifdef MUL_ITER_EARLY_EXIT_EN
                // Once no multiplier bits remain, the remaining rows would
                // only shift. Apply those shifts in one step here. On the
                // last row the shift amount is zero.
                if (mplier_step == '0) begin
                    state_d = S_DONE;
                    z_d     = acc_step >> (CW'(N) - cnt_step);
                end
`else
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    z_d     = acc_step;
                end
`endif
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign z         = z_q;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_iter_ctrl
//
// Self-checking bench for mul_iter_ctrl with N = 10.
// The reference model for each product is x*y using plain arithmetic.
// The expected latency is N cycles in the default build. With
// MUL_ITER_EARLY_EXIT_EN it is max(1, msb_index(y)+1) cycles.
// -----------------------------------------------------------------------------
module tb_mul_iter_ctrl;

    localparam int N = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] z;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] last_z;

    mul_iter_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] yv);
        int m;
        m = 0;
        for (int i = 0; i < N; i++) begin
            if (yv[i]) m = i + 1;
        end
`ifdef MUL_ITER_EARLY_EXIT_EN
        return (m == 0) ? 1 : m;
`else
        return (m >= 0) ? N : N;
`endif
    endfunction

    // Run one full transaction. stall is the number of DONE cycles with
    // out_ready low. junk drives random in_valid, x, y and out_ready during RUN.
    task automatic run_op(input logic [N-1:0] xv, input logic [N-1:0] yv,
                          input int stall, input bit junk);
        logic [63:0] prod;
        int lat;
        bit seen;
        prod = 64'(xv) * 64'(yv);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        x = xv; y = yv; in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (junk) begin
            in_valid = 1'b1;
            x = '0; y = '0;
        end
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("in_ready_run", 64'(in_ready), 64'd0);
        lat = 0;
        seen = 1'b0;
        for (int c = 0; c < 2*N + 4 && !seen; c++) begin
            chk("z_hold_run", 64'(z), 64'(last_z));
            @(posedge clk); #1;
            lat++;
            if (junk) begin
                in_valid  = 1'($urandom_range(0, 1));
                x         = N'($urandom);
                y         = N'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            if (out_valid) seen = 1'b1;
            else chk("busy_run", 64'(busy), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("done_reached", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat(yv)));
        chk("z_product", 64'(z), prod);
        chk("busy_done", 64'(busy), 64'd0);
        chk("in_ready_done", 64'(in_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("out_valid_stall", 64'(out_valid), 64'd1);
            chk("z_stall", 64'(z), prod);
            chk("in_ready_stall", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_fall", 64'(out_valid), 64'd0);
        chk("in_ready_rise", 64'(in_ready), 64'd1);
        chk("z_keep_idle", 64'(z), prod);
        last_z = prod[2*N-1:0];
        $display("op x=%0d y=%0d z=%0d latency=%0d stall=%0d junk=%0d", xv, yv, z, lat, stall, junk);
    endtask

    task automatic reset_mid_run();
        x = 10'd500; y = 10'd600; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_z = '0;
        $display("reset asserted during RUN iteration 4, released");
        run_op(10'd3, 10'd4, 0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        last_z = '0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_z", 64'(z), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(10'd1023, 10'd1023, 0, 1'b0);
        run_op(10'd37,   10'd0,    0, 1'b0);
        run_op(10'd100,  10'd5,    0, 1'b0);
        run_op(10'd12,   10'd13,   5, 1'b0);
        run_op(10'd7,    10'd9,    0, 1'b0);
        run_op(10'd500,  10'd600,  1, 1'b1);
        reset_mid_run();

        for (int i = 0; i < 25; i++) begin
            logic [N-1:0] rx, ry;
            rx = N'($urandom);
            ry = N'($urandom);
            if (i % 8 == 0) rx = '1;
            if (i % 8 == 1) ry = '1;
            if (i % 8 == 2) ry = N'(1) << $urandom_range(0, N - 1);
            run_op(rx, ry, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
